// File: rtl/disparity_select_pkg.sv
// Shared constants, tree node type and level-size helper for disparity_select.
// UNIQUENESS_EN adds second_cost to the node so the uniqueness test can be built.
package disparity_select_pkg;

   localparam int NUM_DISP_DEF   = 108;
   localparam int COST_WIDTH_DEF = 8;
   localparam int DIM_WIDTH_DEF  = 10;
   localparam int DISP_WIDTH_DEF = 7;

   localparam logic [DISP_WIDTH_DEF-1:0] SENTINEL_IDX = '1;
   localparam logic [COST_WIDTH_DEF-1:0] COST_MAX     = '1;

   typedef struct packed {
      logic [COST_WIDTH_DEF-1:0] best_cost;
      logic [DISP_WIDTH_DEF-1:0] best_idx;
`ifdef UNIQUENESS_EN
      logic [COST_WIDTH_DEF-1:0] second_cost;
`endif
   } node_t;

   // Pads odd levels; its all-ones index loses every cost tie against a real entry.
`ifdef UNIQUENESS_EN
   localparam node_t SENTINEL_NODE = '{best_cost: COST_MAX, best_idx: SENTINEL_IDX,
                                       second_cost: COST_MAX};
`else
   localparam node_t SENTINEL_NODE = '{best_cost: COST_MAX, best_idx: SENTINEL_IDX};
`endif

   function automatic int level_size(input int n, input int lvl);
      return (n + (1 << lvl) - 1) >> lvl;
   endfunction

endpackage

// File: rtl/wta_merge.sv
// Combinational merge of two comparison-tree nodes: lower cost wins, ties go to the
// lower index. With UNIQUENESS_EN the runner-up cost is tracked as well.
module wta_merge
   import disparity_select_pkg::*;
(
   input  node_t a_i,
   input  node_t b_i,
   output node_t y_o
);

   logic a_wins;
`ifdef UNIQUENESS_EN
   logic [COST_WIDTH_DEF-1:0] loser_cost;
`endif

   // NOTE: every combinational output gets a full default first, so no path can infer a latch.
   always_comb begin
      a_wins = (a_i.best_cost < b_i.best_cost) ||
               ((a_i.best_cost == b_i.best_cost) && (a_i.best_idx <= b_i.best_idx));
      y_o    = a_wins ? a_i : b_i;
`ifdef UNIQUENESS_EN
      loser_cost = a_wins ? b_i.best_cost : a_i.best_cost;
      if (loser_cost < y_o.second_cost)
         y_o.second_cost = loser_cost;
`endif
   end

endmodule

// File: rtl/disparity_select.sv
// Winner-take-all disparity selector: registered comparison tree plus decision stage.
// Macro UNIQUENESS_EN enables the second-best ratio test driving disp_ok.
module disparity_select
   import disparity_select_pkg::*;
#(
   parameter int NUM_DISP   = NUM_DISP_DEF,
   parameter int COST_WIDTH = COST_WIDTH_DEF,
   parameter int DIM_WIDTH  = DIM_WIDTH_DEF,
   parameter int DISP_WIDTH = DISP_WIDTH_DEF,
   parameter int UNIQ_RATIO = 15
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_DISP*COST_WIDTH-1:0] cost_aggr,
   input  logic [DIM_WIDTH-1:0]           in_row,
   input  logic [DIM_WIDTH-1:0]           in_col,
   input  logic                           in_valid,
   output logic [DISP_WIDTH-1:0]          disp,
   output logic [COST_WIDTH-1:0]          min_cost,
   output logic [DIM_WIDTH-1:0]           out_row,
   output logic [DIM_WIDTH-1:0]           out_col,
   output logic                           disp_ok,
   output logic                           valid
);

   localparam int LEVELS = $clog2(NUM_DISP);

   if (COST_WIDTH != COST_WIDTH_DEF || DISP_WIDTH != DISP_WIDTH_DEF) begin : g_bad_width
      $error("disparity_select: node_t widths are fixed by disparity_select_pkg");
   end
   if (NUM_DISP < 2 || (1 << DISP_WIDTH) <= NUM_DISP) begin : g_bad_disp
      $error("disparity_select: need NUM_DISP >= 2 and 2**DISP_WIDTH > NUM_DISP");
   end
   if (UNIQ_RATIO < 0 || UNIQ_RATIO > 99) begin : g_bad_ratio
      $error("disparity_select: UNIQ_RATIO must lie in 0..99");
   end

   node_t                 leaf_w [NUM_DISP];
   node_t                 root_w;
   logic                  ok_d;
   logic                  vld_q  [LEVELS];
   logic [DIM_WIDTH-1:0]  row_q  [LEVELS];
   logic [DIM_WIDTH-1:0]  col_q  [LEVELS];
   logic [DISP_WIDTH-1:0] disp_q;
   logic [COST_WIDTH-1:0] min_cost_q;
   logic [DIM_WIDTH-1:0]  out_row_q;
   logic [DIM_WIDTH-1:0]  out_col_q;
   logic                  disp_ok_q;
   logic                  valid_q;

   // Leaves start from the sentinel so second_cost is all-ones.
   always_comb begin
      for (int d = 0; d < NUM_DISP; d++) begin
         leaf_w[d]           = SENTINEL_NODE;
         leaf_w[d].best_cost = cost_aggr[d*COST_WIDTH +: COST_WIDTH];
         leaf_w[d].best_idx  = DISP_WIDTH'(d);
      end
   end

   for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
      localparam int N_IN  = level_size(NUM_DISP, l - 1);
      localparam int N_OUT = level_size(NUM_DISP, l);

      node_t in_w   [N_IN];
      node_t node_d [N_OUT];
      node_t node_q [N_OUT];

      if (l == 1) begin : g_src
         assign in_w = leaf_w;
      end else begin : g_src
         assign in_w = g_lvl[l-1].node_q;
      end

      for (genvar i = 0; i < N_OUT; i++) begin : g_node
         node_t b_w;
         if (2*i + 1 < N_IN) begin : g_pair
            assign b_w = in_w[2*i+1];
         end else begin : g_odd
            assign b_w = SENTINEL_NODE;
         end
         wta_merge u_merge (.a_i(in_w[2*i]), .b_i(b_w), .y_o(node_d[i]));
      end

      // NOTE: datapath registers carry no reset; only the valid pipeline decides whether they matter.
      always_ff @(posedge clk) begin
         node_q <= node_d;
      end
   end

   assign root_w = g_lvl[LEVELS].node_q[0];

`ifdef UNIQUENESS_EN
   localparam int UW = COST_WIDTH + 7;
   assign ok_d = (UW'(root_w.second_cost) * UW'(100 - UNIQ_RATIO)) >=
                 (UW'(root_w.best_cost) * UW'(100));
`else
   assign ok_d = 1'b1;
`endif

   always_ff @(posedge clk) begin
      row_q[0] <= in_row;
      col_q[0] <= in_col;
      for (int i = 1; i < LEVELS; i++) begin
         row_q[i] <= row_q[i-1];
         col_q[i] <= col_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < LEVELS; i++) vld_q[i] <= 1'b0;
      end else begin
         vld_q[0] <= in_valid;
         for (int i = 1; i < LEVELS; i++) vld_q[i] <= vld_q[i-1];
      end
   end

   // Decision stage loads only on a valid beat, so outputs hold across bubbles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         disp_q     <= '0;
         min_cost_q <= '0;
         out_row_q  <= '0;
         out_col_q  <= '0;
         disp_ok_q  <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         valid_q <= vld_q[LEVELS-1];
         if (vld_q[LEVELS-1]) begin
            disp_q     <= root_w.best_idx;
            min_cost_q <= root_w.best_cost;
            out_row_q  <= row_q[LEVELS-1];
            out_col_q  <= col_q[LEVELS-1];
            disp_ok_q  <= ok_d;
         end
      end
   end

   assign disp     = disp_q;
   assign min_cost = min_cost_q;
   assign out_row  = out_row_q;
   assign out_col  = out_col_q;
   assign disp_ok  = disp_ok_q;
   assign valid    = valid_q;

endmodule

// File: tb/tb_disparity_select.sv
// Directed self-checking bench for disparity_select (default parameters).
// Expected disp_ok follows UNIQUENESS_EN as seen by this compilation.
module tb_disparity_select;

   localparam int NUM_DISP   = 108;
   localparam int COST_WIDTH = 8;
   localparam int DIM_WIDTH  = 10;
   localparam int DISP_WIDTH = 7;
   localparam int UNIQ_RATIO = 15;
   localparam int LAT        = 8;
`ifdef UNIQUENESS_EN
   localparam bit UNIQ = 1'b1;
`else
   localparam bit UNIQ = 1'b0;
`endif

   logic                           clk = 1'b0;
   logic                           rst = 1'b0;
   logic [NUM_DISP*COST_WIDTH-1:0] cost_aggr = '0;
   logic [DIM_WIDTH-1:0]           in_row = '0;
   logic [DIM_WIDTH-1:0]           in_col = '0;
   logic                           in_valid = 1'b0;
   logic [DISP_WIDTH-1:0]          disp;
   logic [COST_WIDTH-1:0]          min_cost;
   logic [DIM_WIDTH-1:0]           out_row;
   logic [DIM_WIDTH-1:0]           out_col;
   logic                           disp_ok;
   logic                           valid;

   int n_checks = 0;
   int n_fail   = 0;

   disparity_select #(
      .NUM_DISP(NUM_DISP), .COST_WIDTH(COST_WIDTH), .DIM_WIDTH(DIM_WIDTH),
      .DISP_WIDTH(DISP_WIDTH), .UNIQ_RATIO(UNIQ_RATIO)
   ) dut (
      .clk(clk), .rst(rst), .cost_aggr(cost_aggr), .in_row(in_row), .in_col(in_col),
      .in_valid(in_valid), .disp(disp), .min_cost(min_cost), .out_row(out_row),
      .out_col(out_col), .disp_ok(disp_ok), .valid(valid)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic set_all(input int v);
      for (int d = 0; d < NUM_DISP; d++) cost_aggr[d*COST_WIDTH +: COST_WIDTH] = COST_WIDTH'(v);
   endtask

   task automatic set_entry(input int d, input int v);
      cost_aggr[d*COST_WIDTH +: COST_WIDTH] = COST_WIDTH'(v);
   endtask

   // Called at a negedge: presents one beat, then watches valid for 12 cycles.
   task automatic send_pixel(input int r, input int c, output int lat, output int cnt);
      in_row   = DIM_WIDTH'(r);
      in_col   = DIM_WIDTH'(c);
      in_valid = 1'b1;
      lat = -1;
      cnt = 0;
      for (int j = 1; j <= 12; j++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (valid === 1'b1) begin
            cnt++;
            if (lat < 0) lat = j;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      n_checks++; if (disp !== 0)     begin n_fail++; $display("FAIL reset_disp got=%0d exp=0", disp); end
      n_checks++; if (min_cost !== 0) begin n_fail++; $display("FAIL reset_min_cost got=%0d exp=0", min_cost); end
      n_checks++; if (out_row !== 0)  begin n_fail++; $display("FAIL reset_row got=%0d exp=0", out_row); end
      n_checks++; if (out_col !== 0)  begin n_fail++; $display("FAIL reset_col got=%0d exp=0", out_col); end
      n_checks++; if (disp_ok !== 0)  begin n_fail++; $display("FAIL reset_disp_ok got=%0d exp=0", disp_ok); end
      n_checks++; if (valid !== 0)    begin n_fail++; $display("FAIL reset_valid got=%0d exp=0", valid); end
      rst = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         n_checks++; if (valid !== 0) begin n_fail++; $display("FAIL idle_valid got=%0d exp=0", valid); end
      end
   endtask

   task automatic test_single_min();
      int lat, cnt;
      set_all(100);
      set_entry(37, 5);
      send_pixel(12, 345, lat, cnt);
      n_checks++; if (lat !== LAT)     begin n_fail++; $display("FAIL single_latency got=%0d exp=%0d", lat, LAT); end
      n_checks++; if (cnt !== 1)       begin n_fail++; $display("FAIL single_valid_count got=%0d exp=1", cnt); end
      n_checks++; if (disp !== 37)     begin n_fail++; $display("FAIL single_disp got=%0d exp=37", disp); end
      n_checks++; if (min_cost !== 5)  begin n_fail++; $display("FAIL single_min_cost got=%0d exp=5", min_cost); end
      n_checks++; if (disp_ok !== 1)   begin n_fail++; $display("FAIL single_disp_ok got=%0d exp=1", disp_ok); end
      n_checks++; if (out_row !== 12)  begin n_fail++; $display("FAIL single_row got=%0d exp=12", out_row); end
      n_checks++; if (out_col !== 345) begin n_fail++; $display("FAIL single_col got=%0d exp=345", out_col); end
   endtask

   task automatic test_tie();
      int lat, cnt;
      logic exp_ok;
      exp_ok = UNIQ ? 1'b0 : 1'b1;
      set_all(200);
      set_entry(10, 20);
      set_entry(90, 20);
      send_pixel(3, 4, lat, cnt);
      n_checks++; if (lat !== LAT)       begin n_fail++; $display("FAIL tie_latency got=%0d exp=%0d", lat, LAT); end
      n_checks++; if (cnt !== 1)         begin n_fail++; $display("FAIL tie_valid_count got=%0d exp=1", cnt); end
      n_checks++; if (disp !== 10)       begin n_fail++; $display("FAIL tie_disp got=%0d exp=10", disp); end
      n_checks++; if (min_cost !== 20)   begin n_fail++; $display("FAIL tie_min_cost got=%0d exp=20", min_cost); end
      n_checks++; if (disp_ok !== exp_ok) begin n_fail++; $display("FAIL tie_disp_ok got=%0d exp=%0d", disp_ok, exp_ok); end
   endtask

   task automatic test_uniqueness();
      int lat, cnt;
      logic exp_ok;
      for (int k = 0; k < 2; k++) begin
         // 58*85 = 4930 < 5000 fails; 59*85 = 5015 >= 5000 passes.
         exp_ok = UNIQ ? k[0] : 1'b1;
         set_all(255);
         set_entry(3, 50);
         set_entry(60, 58 + k);
         send_pixel(20 + k, 40 + k, lat, cnt);
         n_checks++; if (lat !== LAT)      begin n_fail++; $display("FAIL uniq%0d_latency got=%0d exp=%0d", k, lat, LAT); end
         n_checks++; if (disp !== 3)       begin n_fail++; $display("FAIL uniq%0d_disp got=%0d exp=3", k, disp); end
         n_checks++; if (min_cost !== 50)  begin n_fail++; $display("FAIL uniq%0d_min_cost got=%0d exp=50", k, min_cost); end
         n_checks++; if (disp_ok !== exp_ok) begin n_fail++; $display("FAIL uniq%0d_disp_ok got=%0d exp=%0d", k, disp_ok, exp_ok); end
         n_checks++; if (out_row !== 20 + k) begin n_fail++; $display("FAIL uniq%0d_row got=%0d exp=%0d", k, out_row, 20 + k); end
      end
   endtask

   task automatic test_boundary();
      int lat, cnt;
      int exp_disp, exp_min;
      logic exp_ok;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) begin
            set_all(1);
            set_entry(107, 0);
            exp_disp = 107; exp_min = 0; exp_ok = 1'b1;
         end else begin
            // All 255: entry 0 wins the tie; second 255*85 < 255*100.
            set_all(255);
            exp_disp = 0; exp_min = 255; exp_ok = UNIQ ? 1'b0 : 1'b1;
         end
         send_pixel(1000 + k, 1 + k, lat, cnt);
         n_checks++; if (lat !== LAT)           begin n_fail++; $display("FAIL bound%0d_latency got=%0d exp=%0d", k, lat, LAT); end
         n_checks++; if (cnt !== 1)             begin n_fail++; $display("FAIL bound%0d_valid_count got=%0d exp=1", k, cnt); end
         n_checks++; if (disp !== exp_disp)     begin n_fail++; $display("FAIL bound%0d_disp got=%0d exp=%0d", k, disp, exp_disp); end
         n_checks++; if (min_cost !== exp_min)  begin n_fail++; $display("FAIL bound%0d_min_cost got=%0d exp=%0d", k, min_cost, exp_min); end
         n_checks++; if (disp_ok !== exp_ok)    begin n_fail++; $display("FAIL bound%0d_disp_ok got=%0d exp=%0d", k, disp_ok, exp_ok); end
         n_checks++; if (out_col !== 1 + k)     begin n_fail++; $display("FAIL bound%0d_col got=%0d exp=%0d", k, out_col, 1 + k); end
      end
   endtask

   task automatic test_back_to_back();
      int b;
      logic exp_v;
      for (int t = 0; t < 32; t++) begin
         b     = t - LAT;
         exp_v = (b >= 0 && b < 20);
         n_checks++; if (valid !== exp_v) begin n_fail++; $display("FAIL b2b_valid t=%0d got=%0d exp=%0d", t, valid, exp_v); end
         if (exp_v) begin
            n_checks++; if (disp !== (5*b + 1) % NUM_DISP) begin n_fail++; $display("FAIL b2b_disp beat=%0d got=%0d exp=%0d", b, disp, (5*b + 1) % NUM_DISP); end
            n_checks++; if (min_cost !== b)     begin n_fail++; $display("FAIL b2b_min_cost beat=%0d got=%0d exp=%0d", b, min_cost, b); end
            n_checks++; if (out_row !== 100 + b) begin n_fail++; $display("FAIL b2b_row beat=%0d got=%0d exp=%0d", b, out_row, 100 + b); end
            n_checks++; if (out_col !== 300 + 3*b) begin n_fail++; $display("FAIL b2b_col beat=%0d got=%0d exp=%0d", b, out_col, 300 + 3*b); end
         end
         if (t < 20) begin
            set_all(200);
            set_entry((5*t + 1) % NUM_DISP, t);
            in_row   = DIM_WIDTH'(100 + t);
            in_col   = DIM_WIDTH'(300 + 3*t);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_midstream();
      int lat, cnt, seen;
      for (int t = 0; t < 4; t++) begin
         set_all(150);
         set_entry(7*t, 9);
         in_row   = DIM_WIDTH'(500 + t);
         in_col   = DIM_WIDTH'(600 + t);
         in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++; if (disp !== 0)     begin n_fail++; $display("FAIL midrst_disp got=%0d exp=0", disp); end
      n_checks++; if (min_cost !== 0) begin n_fail++; $display("FAIL midrst_min_cost got=%0d exp=0", min_cost); end
      n_checks++; if (out_row !== 0)  begin n_fail++; $display("FAIL midrst_row got=%0d exp=0", out_row); end
      n_checks++; if (out_col !== 0)  begin n_fail++; $display("FAIL midrst_col got=%0d exp=0", out_col); end
      n_checks++; if (disp_ok !== 0)  begin n_fail++; $display("FAIL midrst_disp_ok got=%0d exp=0", disp_ok); end
      n_checks++; if (valid !== 0)    begin n_fail++; $display("FAIL midrst_valid got=%0d exp=0", valid); end
      @(negedge clk);
      @(negedge clk);
      rst  = 1'b1;
      seen = 0;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         if (valid === 1'b1) seen++;
      end
      n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midrst_flushed got=%0d exp=0", seen); end
      set_all(150);
      set_entry(55, 3);
      send_pixel(700, 800, lat, cnt);
      n_checks++; if (lat !== LAT)     begin n_fail++; $display("FAIL midrst_new_latency got=%0d exp=%0d", lat, LAT); end
      n_checks++; if (cnt !== 1)       begin n_fail++; $display("FAIL midrst_new_count got=%0d exp=1", cnt); end
      n_checks++; if (disp !== 55)     begin n_fail++; $display("FAIL midrst_new_disp got=%0d exp=55", disp); end
      n_checks++; if (min_cost !== 3)  begin n_fail++; $display("FAIL midrst_new_min_cost got=%0d exp=3", min_cost); end
      n_checks++; if (out_row !== 700) begin n_fail++; $display("FAIL midrst_new_row got=%0d exp=700", out_row); end
      n_checks++; if (out_col !== 800) begin n_fail++; $display("FAIL midrst_new_col got=%0d exp=800", out_col); end
      n_checks++; if (disp_ok !== 1)   begin n_fail++; $display("FAIL midrst_new_disp_ok got=%0d exp=1", disp_ok); end
   endtask

   initial begin
      test_reset();
      test_single_min();
      test_tie();
      test_uniqueness();
      test_boundary();
      test_back_to_back();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
